// File: rtl/hazard_ctrl.sv
// Hazard controller for the five-stage RV32I pipe: forwarding, load-use stalls, redirect flushes, memory-wait freeze.
// Optional event counters are built when HAZARD_PERF_EN is defined.
module hazard_ctrl #(
   parameter int MEM_TIMEOUT = 255,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       Rs1D,
   input  logic [4:0]       Rs2D,
   input  logic [4:0]       Rs1E,
   input  logic [4:0]       Rs2E,
   input  logic [4:0]       RdE,
   input  logic             RegWriteE,
   input  logic [1:0]       ResultSrcE,
   input  logic             PCSrcE,
   input  logic [4:0]       RdM,
   input  logic             RegWriteM,
   input  logic             MemReqM,
   input  logic             MemReadyM,
   input  logic [4:0]       RdW,
   input  logic             RegWriteW,
   output logic             StallF,
   output logic             StallD,
   output logic             StallE,
   output logic             StallM,
   output logic             FlushD,
   output logic             FlushE,
   output logic             FlushW,
   output logic [1:0]       ForwardAE,
   output logic [1:0]       ForwardBE,
   output logic             mem_err
`ifdef HAZARD_PERF_EN
   ,
   output logic [CNT_W-1:0] perf_stall,
   output logic [CNT_W-1:0] perf_flush,
   output logic [CNT_W-1:0] perf_memwait
`endif
);

   typedef enum logic {RUN, MEM_WAIT} state_t;

   state_t      state_q, state_d;
   logic [15:0] wait_cnt_q, wait_cnt_d;
   logic        mem_err_q, mem_err_d;
   logic        mask_q, mask_d;
   logic        lw_stall, mem_stall, timeout, freeze, redirect, lw_win;

   function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
      if (RegWriteM && (RdM != 5'd0) && (RdM == rs))
         return 2'b10;
      else if (RegWriteW && (RdW != 5'd0) && (RdW == rs))
         return 2'b01;
      return 2'b00;
   endfunction

   assign lw_stall  = (ResultSrcE == 2'b01) && RegWriteE && (RdE != 5'd0) &&
                      ((RdE == Rs1D) || (RdE == Rs2D));
   // The mask keeps a just-timed-out request from re-entering the wait for one cycle.
   assign mem_stall = MemReqM && !MemReadyM && !mask_q;
   assign timeout   = (state_q == MEM_WAIT) && mem_stall &&
                      (wait_cnt_q == 16'(MEM_TIMEOUT));
   assign freeze    = mem_stall && !timeout;
   assign redirect  = !freeze && PCSrcE;
   assign lw_win    = !freeze && !PCSrcE && lw_stall;
   assign mem_err   = mem_err_q;

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      mem_err_d  = mem_err_q;
      mask_d     = 1'b0;
      StallF     = 1'b0;
      StallD     = 1'b0;
      StallE     = 1'b0;
      StallM     = 1'b0;
      FlushD     = 1'b0;
      FlushE     = 1'b0;
      FlushW     = freeze || timeout;
      ForwardAE  = fwd_sel(Rs1E);
      ForwardBE  = fwd_sel(Rs2E);

      if (freeze) begin
         StallF = 1'b1;
         StallD = 1'b1;
         StallE = 1'b1;
         StallM = 1'b1;
      end else if (redirect) begin
         FlushD = 1'b1;
         FlushE = 1'b1;
      end else if (lw_win) begin
         StallF = 1'b1;
         StallD = 1'b1;
         FlushE = 1'b1;
      end

      case (state_q)
         RUN: begin
            if (mem_stall) begin
               state_d    = MEM_WAIT;
               wait_cnt_d = 16'd1;
            end
         end
         default: begin
            if (timeout) begin
               state_d    = RUN;
               wait_cnt_d = 16'd0;
               mem_err_d  = 1'b1;
               mask_d     = 1'b1;
            end else if (!mem_stall) begin
               state_d    = RUN;
               wait_cnt_d = 16'd0;
            end else begin
               wait_cnt_d = wait_cnt_q + 16'd1;
            end
         end
      endcase

      if (!rst) begin
         StallF    = 1'b0;
         StallD    = 1'b0;
         StallE    = 1'b0;
         StallM    = 1'b0;
         FlushD    = 1'b0;
         FlushE    = 1'b0;
         FlushW    = 1'b0;
         ForwardAE = 2'b00;
         ForwardBE = 2'b00;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= RUN;
         wait_cnt_q <= 16'd0;
         mem_err_q  <= 1'b0;
         mask_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         mem_err_q  <= mem_err_d;
         mask_q     <= mask_d;
      end
   end

`ifdef HAZARD_PERF_EN
   logic [CNT_W-1:0] perf_stall_q, perf_flush_q, perf_memwait_q;

   // Counters stick at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
      if (en && (v != {CNT_W{1'b1}}))
         return v + {{(CNT_W-1){1'b0}}, 1'b1};
      return v;
   endfunction

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_stall_q   <= '0;
         perf_flush_q   <= '0;
         perf_memwait_q <= '0;
      end else begin
         perf_stall_q   <= sat_inc(perf_stall_q, lw_win);
         perf_flush_q   <= sat_inc(perf_flush_q, redirect);
         perf_memwait_q <= sat_inc(perf_memwait_q, freeze);
      end
   end

   assign perf_stall   = perf_stall_q;
   assign perf_flush   = perf_flush_q;
   assign perf_memwait = perf_memwait_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: forwarding, load-use, redirect, memory wait, timeout and reset.
module tb_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
   logic       RegWriteE, PCSrcE, RegWriteM, MemReqM, MemReadyM, RegWriteW;
   logic [1:0] ResultSrcE;
   logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, mem_err;
   logic [1:0] ForwardAE, ForwardBE;
`ifdef HAZARD_PERF_EN
   logic [3:0] perf_stall, perf_flush, perf_memwait;
`endif

   int tests = 0;
   int fails = 0;

   hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
      .clk(clk), .rst(rst),
      .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
      .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
      .RdM(RdM), .RegWriteM(RegWriteM), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
      .RdW(RdW), .RegWriteW(RegWriteW),
      .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
      .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .mem_err(mem_err)
`ifdef HAZARD_PERF_EN
      , .perf_stall(perf_stall), .perf_flush(perf_flush), .perf_memwait(perf_memwait)
`endif
   );

   always #5 clk = ~clk;

   // Control vector order: {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_ctl(input string tag, input logic [6:0] exp);
      #1 chk(tag, {25'd0, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}, {25'd0, exp});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
      RegWriteE = 0; PCSrcE = 0; RegWriteM = 0; MemReqM = 0; MemReadyM = 0;
      RegWriteW = 0; ResultSrcE = 2'b00;
   endtask

   initial begin
      idle();
      rst = 1'b0;
      // Hazards present while in reset must not reach the outputs.
      RegWriteM = 1; RdM = 3; Rs1E = 3; MemReqM = 1; PCSrcE = 1;
      chk_ctl("reset_ctl", 7'b0000000);
      chk("reset_fwdA", {30'd0, ForwardAE}, 32'd0);
      chk("reset_err", {31'd0, mem_err}, 32'd0);
      tick(); tick();
      idle();
      rst = 1'b1;
      tick();

      // Forwarding priority and x0
      RegWriteM = 1; RdM = 7; RegWriteW = 1; RdW = 7; Rs1E = 7; Rs2E = 7;
      #1 chk("fwdB_M_over_W", {30'd0, ForwardBE}, 32'd2);
      chk("fwdA_M_over_W", {30'd0, ForwardAE}, 32'd2);
      RegWriteM = 0;
      #1 chk("fwdB_W", {30'd0, ForwardBE}, 32'd1);
      RegWriteM = 1; RdM = 0; Rs2E = 0; RdW = 0;
      #1 chk("fwdB_x0", {30'd0, ForwardBE}, 32'd0);
      RegWriteM = 0; RegWriteW = 0; RdW = 7;
      #1 chk("fwdA_no_write", {30'd0, ForwardAE}, 32'd0);
      idle();
      tick();

      // Load-use on Rs1D: one bubble, then forwarded from M and W
      ResultSrcE = 2'b01; RegWriteE = 1; RdE = 5; Rs1D = 5;
      chk_ctl("lw_rs1", 7'b1100010);
      tick();
      ResultSrcE = 2'b00; RegWriteE = 0; RdE = 0; Rs1E = 5; RegWriteM = 1; RdM = 5;
      chk_ctl("lw_bubble_done", 7'b0000000);
      chk("lw_fwd_M", {30'd0, ForwardAE}, 32'd2);
      tick();
      RegWriteM = 0; RdM = 0; RegWriteW = 1; RdW = 5;
      #1 chk("lw_fwd_W", {30'd0, ForwardAE}, 32'd1);
      idle();
      ResultSrcE = 2'b01; RegWriteE = 1; RdE = 9; Rs2D = 9;
      chk_ctl("lw_rs2", 7'b1100010);
      RdE = 0; Rs2D = 0;
      chk_ctl("lw_rd_x0", 7'b0000000);
      RdE = 9; Rs2D = 9; ResultSrcE = 2'b00;
      chk_ctl("not_a_load", 7'b0000000);

      // Redirect beats load-use
      ResultSrcE = 2'b01; PCSrcE = 1;
      chk_ctl("pcsrc_over_lw", 7'b0000110);
      tick();

      // Memory wait with redirect and load-use pending: 3 frozen cycles
      MemReqM = 1; MemReadyM = 0;
      chk_ctl("memwait_c0", 7'b1111001);
      tick();
      chk_ctl("memwait_c1", 7'b1111001);
      tick();
      chk_ctl("memwait_c2", 7'b1111001);
      tick();
      MemReadyM = 1;
      chk_ctl("memwait_release", 7'b0000110);
      tick();
      idle();

      // Same-cycle acknowledge
      MemReqM = 1; MemReadyM = 1;
      chk_ctl("mem_same_cycle", 7'b0000000);
      tick();
      MemReadyM = 0;
      chk_ctl("mem_same_cycle_run", 7'b1111001);
      MemReadyM = 1;
      tick();
      idle();
      tick();

      // Timeout after 4 wait cycles, sticky error, one-cycle mask
      MemReqM = 1; MemReadyM = 0;
      for (int i = 0; i < 4; i++) begin
         chk_ctl($sformatf("to_stall_%0d", i), 7'b1111001);
         #1 chk($sformatf("to_err_low_%0d", i), {31'd0, mem_err}, 32'd0);
         tick();
      end
      chk_ctl("to_release", 7'b0000001);
      tick();
      chk_ctl("to_masked", 7'b0000000);
      chk("to_err_set", {31'd0, mem_err}, 32'd1);
      tick();
      chk_ctl("to_reenter", 7'b1111001);
      MemReadyM = 1;
      tick();
      idle();
      tick();
      chk("err_sticky", {31'd0, mem_err}, 32'd1);

      // Asynchronous reset during MEM_WAIT
      MemReqM = 1; MemReadyM = 0;
      tick();
      #2 rst = 1'b0;
      #1 chk("rst_async_err", {31'd0, mem_err}, 32'd0);
      chk_ctl("rst_async_ctl", 7'b0000000);
      idle();
      tick();
      rst = 1'b1;
      tick();
      MemReqM = 1; MemReadyM = 0;
      for (int i = 0; i < 4; i++) begin
         chk_ctl($sformatf("post_rst_stall_%0d", i), 7'b1111001);
         tick();
      end
      chk_ctl("post_rst_timeout", 7'b0000001);
      idle();
      tick();

`ifdef HAZARD_PERF_EN
      rst = 1'b0;
      tick();
      rst = 1'b1;
      ResultSrcE = 2'b01; RegWriteE = 1; RdE = 5; Rs1D = 5;
      for (int i = 0; i < 20; i++) tick();
      chk("perf_stall_sat", {28'd0, perf_stall}, 32'd15);
      idle();
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
